// File: rtl/dmem_access_unit.sv
// MEM-stage load/store responder. Issues RV32 byte/half/word accesses on a
// ready/ack data memory, stalls the pipeline via BUSYWAIT while an access is
// outstanding, and returns extended load data. Misaligned, illegal and
// timed-out accesses raise a one-cycle ACCESS_FAULT pulse.
module dmem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [31:0]       MEM_WRITE_DATA,
    input  logic              MEM_MEM_READ,
    input  logic              MEM_MEM_WRITE,
    input  logic [2:0]        MEM_FUNC3,
    output logic [31:0]       MEM_READ_DATA,
    output logic              BUSYWAIT,
    output logic              ACCESS_FAULT,
    output logic              DM_REQ,
    output logic              DM_WE,
    output logic [ADDR_W-3:0] DM_ADDR,
    output logic [31:0]       DM_WDATA,
    output logic [3:0]        DM_BE,
    input  logic [31:0]       DM_RDATA,
    input  logic              DM_ACK
);

    // Last ACCESS cycle before the access is abandoned.
    localparam logic [9:0] CntLast = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              busy;

    // Request decode: legality of funct3/strobes and alignment
    logic req_any, is_half, is_word, f3_legal, aligned, req_ok;
    always_comb begin
        req_any = MEM_MEM_READ | MEM_MEM_WRITE;
        is_half = (MEM_FUNC3[1:0] == 2'b01);
        is_word = (MEM_FUNC3[1:0] == 2'b10);
        if (MEM_MEM_READ && MEM_MEM_WRITE) begin
            f3_legal = 1'b0;
        end else if (MEM_MEM_READ) begin
            f3_legal = (MEM_FUNC3 != 3'b011) && (MEM_FUNC3 != 3'b110) &&
                       (MEM_FUNC3 != 3'b111);
        end else begin
            f3_legal = !MEM_FUNC3[2] && (MEM_FUNC3[1:0] != 2'b11);
        end
        if (is_half) begin
            aligned = !MEM_ADDR[0];
        end else if (is_word) begin
            aligned = (MEM_ADDR[1:0] == 2'b00);
        end else begin
            aligned = 1'b1;
        end
        req_ok = f3_legal && aligned;
    end

    // Byte enables and lane-replicated store data for a new request
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    always_comb begin
        if (is_word) begin
            be_new    = 4'b1111;
            wdata_new = MEM_WRITE_DATA;
        end else if (is_half) begin
            be_new    = MEM_ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{MEM_WRITE_DATA[15:0]}};
        end else begin
            be_new    = 4'b0001 << MEM_ADDR[1:0];
            wdata_new = {4{MEM_WRITE_DATA[7:0]}};
        end
    end

    // Lane extraction and sign/zero extension of the returned word
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = DM_RDATA[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = DM_RDATA;
        endcase
    end

    // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        busy    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    if (req_ok) begin
                        busy    = 1'b1;
                        req_d   = 1'b1;
                        we_d    = MEM_MEM_WRITE;
                        addr_d  = MEM_ADDR[ADDR_W-1:2];
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        f3_d    = MEM_FUNC3;
                        off_d   = MEM_ADDR[1:0];
                        cnt_d   = '0;
                        state_d = StAccess;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            StAccess: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 10'd1;
                // ACK takes priority over a coincident timeout
                if (DM_ACK) begin
                    if (!we_q) begin
                        rdata_d = ld_ext;
                    end
                    req_d   = 1'b0;
                    be_d    = 4'b0000;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    be_d    = 4'b0000;
                    fault_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // The request still on the inputs is the one just completed
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    // Stall is masked during reset so a pending request cannot hold the pipe
    assign BUSYWAIT      = busy & RST;
    assign ACCESS_FAULT  = fault_q;
    assign MEM_READ_DATA = rdata_q;
    assign DM_REQ        = req_q;
    assign DM_WE         = we_q;
    assign DM_ADDR       = addr_q;
    assign DM_WDATA      = wdata_q;
    assign DM_BE         = be_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: table of access vectors with
// expected results queued at drive time and compared on completion, plus a
// hand-written reset-mid-access / stale-ACK sequence.
module tb_dmem_access_unit;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 8;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [ADDR_W-1:0] MEM_ADDR = '0;
    logic [31:0]       MEM_WRITE_DATA = '0;
    logic              MEM_MEM_READ = 1'b0;
    logic              MEM_MEM_WRITE = 1'b0;
    logic [2:0]        MEM_FUNC3 = '0;
    logic [31:0]       MEM_READ_DATA;
    logic              BUSYWAIT;
    logic              ACCESS_FAULT;
    logic              DM_REQ;
    logic              DM_WE;
    logic [ADDR_W-3:0] DM_ADDR;
    logic [31:0]       DM_WDATA;
    logic [3:0]        DM_BE;
    logic [31:0]       DM_RDATA = '0;
    logic              DM_ACK = 1'b0;

    dmem_access_unit #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_MEM_READ  (MEM_MEM_READ),
        .MEM_MEM_WRITE (MEM_MEM_WRITE),
        .MEM_FUNC3     (MEM_FUNC3),
        .MEM_READ_DATA (MEM_READ_DATA),
        .BUSYWAIT      (BUSYWAIT),
        .ACCESS_FAULT  (ACCESS_FAULT),
        .DM_REQ        (DM_REQ),
        .DM_WE         (DM_WE),
        .DM_ADDR       (DM_ADDR),
        .DM_WDATA      (DM_WDATA),
        .DM_BE         (DM_BE),
        .DM_RDATA      (DM_RDATA),
        .DM_ACK        (DM_ACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;   // ACCESS cycle carrying DM_ACK, 0 = never
        logic        fault;
        logic [3:0]  be;
        logic [29:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] rd_data;
        logic        hold;      // MEM_READ_DATA must keep its previous value
        int          busy;      // BUSYWAIT-high cycles, 0 = rejected in IDLE
    } vec_t;

    vec_t        tbl[16];
    vec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    function automatic vec_t mk(string nm, logic rd, logic wr, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int ack, logic fault,
                                logic [3:0] be, logic [29:0] da, logic [31:0] dwd,
                                logic [31:0] rdd, logic hold, int busy);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.ack_cyc = ack; v.fault = fault;
        v.be = be; v.dm_addr = da; v.dm_wdata = dwd; v.rd_data = rdd;
        v.hold = hold; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MEM_MEM_READ  = 1'b0;
        MEM_MEM_WRITE = 1'b0;
        DM_ACK        = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   busy_n;
        bit   done;
        exp_q.push_back(v);
        @(negedge CLK);
        MEM_ADDR       = v.addr;
        MEM_WRITE_DATA = v.wdata;
        MEM_MEM_READ   = v.rd;
        MEM_MEM_WRITE  = v.wr;
        MEM_FUNC3      = v.f3;
        DM_RDATA       = v.rdata;
        #1;
        if (v.busy == 0) begin
            check({v.name, "_busy"}, 32'(BUSYWAIT), 32'd0);
            @(negedge CLK);
            #1;
            check({v.name, "_req"}, 32'(DM_REQ), 32'd0);
            check({v.name, "_fault"}, 32'(ACCESS_FAULT), 32'd1);
            idle_inputs();
            @(negedge CLK);
            #1;
            check({v.name, "_fault_pulse"}, 32'(ACCESS_FAULT), 32'd0);
            e = exp_q.pop_front();
            check({e.name, "_rdata_held"}, MEM_READ_DATA, last_rd);
        end else begin
            check({v.name, "_busy_idle"}, 32'(BUSYWAIT), 32'd1);
            busy_n = 1;
            done   = 1'b0;
            for (int n = 1; n <= 4 * TIMEOUT && !done; n++) begin
                @(negedge CLK);
                DM_ACK = 1'b0;
                #1;
                if (BUSYWAIT) begin
                    busy_n++;
                    check({v.name, "_req_held"}, 32'(DM_REQ), 32'd1);
                    check({v.name, "_be"}, 32'(DM_BE), 32'(v.be));
                    if (n == 1) begin
                        check({v.name, "_we"}, 32'(DM_WE), 32'(v.wr));
                        check({v.name, "_addr"}, 32'(DM_ADDR), 32'(v.dm_addr));
                        if (v.wr) check({v.name, "_wdata"}, DM_WDATA, v.dm_wdata);
                    end
                    if (n == v.ack_cyc) DM_ACK = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            e = exp_q.pop_front();
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL %s_complete: BUSYWAIT still high after %0d cycles, required low",
                         e.name, 4 * TIMEOUT);
            end else begin
                check({e.name, "_busy_cycles"}, 32'(busy_n), 32'(e.busy));
                check({e.name, "_fault"}, 32'(ACCESS_FAULT), 32'(e.fault));
                check({e.name, "_req_drop"}, 32'(DM_REQ), 32'd0);
                check({e.name, "_be_drop"}, 32'(DM_BE), 32'd0);
                check({e.name, "_rdata"}, MEM_READ_DATA, e.hold ? last_rd : e.rd_data);
                if (!e.hold) last_rd = e.rd_data;
            end
            idle_inputs();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         name        rd wr f3      addr       wdata         rdata        ack flt be     daddr     dwdata        rd_data    hld busy
        tbl[0]  = mk("lw",       1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 0, 4'hF, 30'h40, 32'h0,        32'hDEADBEEF, 0, 3);
        tbl[1]  = mk("lb",       1, 0, 3'b000, 32'h103, 32'h0,        32'h80123456, 1, 0, 4'h8, 30'h40, 32'h0,        32'hFFFFFF80, 0, 2);
        tbl[2]  = mk("lbu",      1, 0, 3'b100, 32'h103, 32'h0,        32'h80123456, 3, 0, 4'h8, 30'h40, 32'h0,        32'h00000080, 0, 4);
        tbl[3]  = mk("lh",       1, 0, 3'b001, 32'h102, 32'h0,        32'h80123456, 1, 0, 4'hC, 30'h40, 32'h0,        32'hFFFF8012, 0, 2);
        tbl[4]  = mk("lhu",      1, 0, 3'b101, 32'h100, 32'h0,        32'h1234F00D, 1, 0, 4'h3, 30'h40, 32'h0,        32'h0000F00D, 0, 2);
        tbl[5]  = mk("lb_pos",   1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 0, 4'h2, 30'h40, 32'h0,        32'h0000007F, 0, 3);
        tbl[6]  = mk("sb",       0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        1, 0, 4'h2, 30'h80, 32'hABABABAB, 32'h0,        1, 2);
        tbl[7]  = mk("sh",       0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0,        2, 0, 4'hC, 30'h80, 32'h12341234, 32'h0,        1, 3);
        tbl[8]  = mk("sw",       0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        1, 0, 4'hF, 30'h81, 32'hCAFEF00D, 32'h0,        1, 2);
        tbl[9]  = mk("lw_mis",   1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 4'h0, 30'h0,  32'h0,        32'h0,        1, 0);
        tbl[10] = mk("sh_mis",   0, 1, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1, 4'h0, 30'h0,  32'h0,        32'h0,        1, 0);
        tbl[11] = mk("ld_f3_011",1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 4'h0, 30'h0,  32'h0,        32'h0,        1, 0);
        tbl[12] = mk("rd_and_wr",1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 1, 4'h0, 30'h0,  32'h0,        32'h0,        1, 0);
        tbl[13] = mk("st_f3_100",0, 1, 3'b100, 32'h200, 32'h0,        32'h0,        0, 1, 4'h0, 30'h0,  32'h0,        32'h0,        1, 0);
        tbl[14] = mk("timeout",  1, 0, 3'b010, 32'h10C, 32'h0,        32'h11223344, 0, 1, 4'hF, 30'h43, 32'h0,        32'h0,        1, 9);
        tbl[15] = mk("ack_at_to",1, 0, 3'b010, 32'h10C, 32'h0,        32'h11223344, 8, 0, 4'hF, 30'h43, 32'h0,        32'h11223344, 0, 9);

        // Reset state
        #1;
        check("rst_req", 32'(DM_REQ), 32'd0);
        check("rst_we", 32'(DM_WE), 32'd0);
        check("rst_be", 32'(DM_BE), 32'd0);
        check("rst_addr", 32'(DM_ADDR), 32'd0);
        check("rst_wdata", DM_WDATA, 32'd0);
        check("rst_rdata", MEM_READ_DATA, 32'd0);
        check("rst_fault", 32'(ACCESS_FAULT), 32'd0);
        check("rst_busy", 32'(BUSYWAIT), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(tbl[i]);

        // Reset asserted two cycles into ACCESS
        @(negedge CLK);
        MEM_ADDR     = 32'h100;
        MEM_FUNC3    = 3'b010;
        MEM_MEM_READ = 1'b1;
        DM_RDATA     = 32'h55AA55AA;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("mid_req_before_rst", 32'(DM_REQ), 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_req", 32'(DM_REQ), 32'd0);
        check("mid_rst_busy", 32'(BUSYWAIT), 32'd0);
        check("mid_rst_be", 32'(DM_BE), 32'd0);
        check("mid_rst_fault", 32'(ACCESS_FAULT), 32'd0);
        check("mid_rst_rdata", MEM_READ_DATA, 32'd0);
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        last_rd = 32'd0;

        // Stale ACK in IDLE must be ignored
        @(negedge CLK);
        DM_ACK = 1'b1;
        @(negedge CLK);
        DM_ACK = 1'b0;
        #1;
        check("stale_ack_busy", 32'(BUSYWAIT), 32'd0);
        check("stale_ack_req", 32'(DM_REQ), 32'd0);
        check("stale_ack_fault", 32'(ACCESS_FAULT), 32'd0);
        check("stale_ack_rdata", MEM_READ_DATA, 32'd0);

        run_vec(mk("lw_after_rst", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 1, 0,
                   4'hF, 30'hC0, 32'h0, 32'h0BADF00D, 0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
